// File: rtl/instr_prefetch_queue.sv
// Instruction fetch stage: single-outstanding imem requests fill a DEPTH-entry
// prefetch FIFO of {word, pc}; a branch flushes the FIFO and redirects fetch.
module instr_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        code_valid,
  output logic [31:0] code,
  output logic [31:0] code_pc,
  input  logic        code_ready
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t        state;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic          pop;
  logic          push;
  logic [31:0]   target;
  logic [CW:0]   after_pop;
  logic [CW:0]   after_push_pop;

  // Handshake qualifiers and occupancy lookahead used by the fetch FSM.
  always_comb begin
    pop            = code_valid && code_ready && !branch_valid;
    push           = (state == REQ) && imem_ack && !branch_valid;
    target         = branch_target & 32'hFFFF_FFFC;
    after_pop      = {1'b0, count} - (CW+1)'(pop);
    after_push_pop = {1'b0, count} + (CW+1)'(1) - (CW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr] <= imem_rdata;
      pc_q[wr_ptr]   <= imem_addr;
    end
  end

  assign code_valid = (count != '0);
  assign code       = code_valid ? word_q[rd_ptr] : '0;
  assign code_pc    = code_valid ? pc_q[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetch_pc  <= RESET_PC;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      // A redirect discards everything queued, even a same-cycle pop or push.
      if (branch_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end

      case (state)
        IDLE: begin
          if (branch_valid) begin
            fetch_pc  <= target;
            imem_addr <= target;
            imem_req  <= 1'b1;
            state     <= REQ;
          end else if (after_pop < DEPTH_X) begin
            imem_addr <= fetch_pc;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (branch_valid && !imem_ack) begin
            fetch_pc <= target;
            state    <= DISCARD;
          end else if (branch_valid) begin
            fetch_pc  <= target;
            imem_addr <= target;
          end else if (imem_ack) begin
            fetch_pc <= imem_addr + 32'd4;
            if (after_push_pop < DEPTH_X) begin
              imem_addr <= imem_addr + 32'd4;
            end else begin
              imem_req <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        DISCARD: begin
          // Old request stays on the bus until acked; its word is thrown away.
          if (branch_valid) fetch_pc <= target;
          if (imem_ack) begin
            imem_addr <= branch_valid ? target : fetch_pc;
            state     <= REQ;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
